// File: rtl/loss_accum_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : loss_pkg                                                         |
// | Shared types and defaults for the streaming L1/L2 loss reducer.            |
// | Contents: default fixed-point geometry (IL/FL/W), lane/job/guard defaults, |
// |           fx_t operand type, FSM and loss-mode enumerations, sat_w clamp.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package loss_pkg;

  localparam int LOSS_IL    = 8;
  localparam int LOSS_FL    = 12;
  localparam int W          = LOSS_IL + LOSS_FL;
  localparam int LOSS_LANES = 4;
  localparam int LOSS_MAXN  = 1024;
  localparam int LOSS_GUARD = 8;

  typedef logic signed [W-1:0] fx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    LOSS_L1 = 1'b0,
    LOSS_L2 = 1'b1
  } loss_mode_t;

  // Clamp a wide signed value into the signed W-bit operand range.
  function automatic fx_t sat_w(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (W-1)) - 64'sd1;
    lo = -(64'sd1 <<< (W-1));
    if (v > hi)      return fx_t'(hi);
    else if (v < lo) return fx_t'(lo);
    else             return fx_t'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loss_accum_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : loss_accum_stream_if                                           |
// | Input beat stream (valid/ready, LANES x DW yhat/y) and result stream       |
// | (valid/ready, sum, ovf) of the loss reducer.                               |
// | Modports: slave  - the reducer (accepts beats, produces the result)        |
// |           master - the producer/consumer side                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface loss_accum_stream_if
  import loss_pkg::*;
#(
  parameter int DW    = W,
  parameter int LANES = LOSS_LANES
);

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES-1:0][DW-1:0]   yhat;   // lane 0 = lowest element index
  logic [LANES-1:0][DW-1:0]   y;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [DW-1:0]       sum;
  logic                       ovf;

  modport slave (
    input  in_valid, yhat, y, out_ready,
    output in_ready, out_valid, sum, ovf
  );

  modport master (
    output in_valid, yhat, y, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

endinterface
`default_nettype wire

// File: rtl/loss_accum_stream_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : loss_lane                                                        |
// | One first-stage lane: d = yhat - y, then |d| (L1) or (d*d)>>>FL (L2),      |
// | saturated to the positive W-bit range, forced to zero when masked.         |
// | Ports: yhat, y (DW) operands; mode; mask; val (DW, never negative);        |
// |        sat flags a saturation on an unmasked lane.                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module loss_lane
  import loss_pkg::*;
#(
  parameter int DW = W,
  parameter int FL = LOSS_FL
) (
  input  logic [DW-1:0] yhat,
  input  logic [DW-1:0] y,
  input  loss_mode_t    mode,
  input  logic          mask,
  output logic [DW-1:0] val,
  output logic          sat
);

  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

  logic signed [DW:0]       d;
  logic [DW:0]              mag;
  logic signed [2*DW+1:0]   d_ext;
  logic signed [2*DW+1:0]   sq;
  logic [2*DW+1:0]          sh;
  logic                     l1_sat;
  logic                     l2_sat;
  logic [DW-1:0]            l1_val;
  logic [DW-1:0]            l2_val;

  // One extra bit keeps the difference exact.
  assign d      = $signed({yhat[DW-1], yhat}) - $signed({y[DW-1], y});
  assign mag    = d[DW] ? $unsigned(-d) : $unsigned(d);
  assign l1_sat = mag[DW] | mag[DW-1];
  assign l1_val = l1_sat ? MAXV : mag[DW-1:0];

  // Square is non-negative, so the arithmetic shift equals a logical one.
  assign d_ext  = {{(DW+1){d[DW]}}, d};
  assign sq     = d_ext * d_ext;
  assign sh     = $unsigned(sq) >> FL;
  assign l2_sat = |sh[2*DW+1:DW-1];
  assign l2_val = l2_sat ? MAXV : sh[DW-1:0];

  assign val = mask ? '0 : ((mode == LOSS_L2) ? l2_val : l1_val);
  assign sat = !mask && ((mode == LOSS_L2) ? l2_sat : l1_sat);

endmodule
`default_nettype wire

// File: rtl/loss_accum_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : loss_accum_stream                                                |
// | Streaming multi-lane L1/L2 loss reducer over a job of num elements.        |
// | Ports: clk, reset_n (async active-low); start/mode/num job launch;         |
// |        busy (RUN/DRAIN/DONE); bus (slave) carries the beat stream         |
// |        (in_valid/in_ready/yhat/y) and result (out_valid/out_ready/sum/ovf).|
// | Pipeline: S1 lane registers -> S2 adder tree into ACC -> DONE register.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module loss_accum_stream
  import loss_pkg::*;
#(
  parameter int IL    = LOSS_IL,
  parameter int FL    = LOSS_FL,
  parameter int LANES = LOSS_LANES,
  parameter int MAXN  = LOSS_MAXN,
  parameter int GUARD = LOSS_GUARD
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [$clog2(MAXN+1)-1:0] num,
  output logic                      busy,
  loss_accum_stream_if.slave        bus
);

  localparam int OPW = IL + FL;
  localparam int NW  = $clog2(MAXN + 1);
  localparam int LW  = OPW + $clog2(LANES);
  localparam int AW  = OPW + GUARD;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] RES_MAX = AW'({(OPW-1){1'b1}});
  localparam logic [NW-1:0] MAXN_C  = NW'(MAXN);
  localparam logic [NW-1:0] LANES_C = NW'(LANES);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]                 state_q, state_d;
  logic [NW-1:0]              rem_q, rem_d;
  loss_mode_t                 mode_q, mode_d;
  logic                       s1_valid_q, s1_valid_d;
  logic [LANES-1:0][OPW-1:0]  s1_val_q, s1_val_d;
  logic [AW-1:0]              acc_q, acc_d;
  logic [OPW-1:0]             sum_q, sum_d;
  logic                       ovf_q, ovf_d;

  logic [LANES-1:0][OPW-1:0]  lane_val;
  logic [LANES-1:0]           lane_sat;
  logic [NW-1:0]              num_c;
  logic                       beat;
  logic [LW-1:0]              tree;
  logic [AW:0]                acc_sum;

  assign num_c = (num > MAXN_C) ? MAXN_C : num;
  assign beat  = bus.in_valid && (state_q == ST_RUN);

  // Lanes at or beyond the remaining count belong to no element of this job.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    loss_lane #(.DW(OPW), .FL(FL)) u_lane (
      .yhat (bus.yhat[i]),
      .y    (bus.y[i]),
      .mode (mode_q),
      .mask (rem_q <= NW'(i)),
      .val  (lane_val[i]),
      .sat  (lane_sat[i])
    );
  end

  // Lane values are never negative, so zero extension is exact.
  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) begin
      tree = tree + LW'(s1_val_q[i]);
    end
  end

  assign acc_sum = {1'b0, acc_q} + (AW+1)'(tree);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    s1_valid_d = beat;
    s1_val_d   = beat ? lane_val : s1_val_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;

    if (s1_valid_q) begin
      if (acc_sum > {1'b0, ACC_MAX}) begin
        acc_d = ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[AW-1:0];
      end
    end
    if (beat && (|lane_sat)) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = loss_mode_t'(mode);
          rem_d   = num_c;
          acc_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = (num_c == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat) begin
          if (rem_q <= LANES_C) begin
            rem_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            rem_d   = rem_q - LANES_C;
          end
        end
      end
      ST_DRAIN: begin
        // S2 folds into ACC on the same edge S1 empties, so ACC is final here.
        if (!s1_valid_q) begin
          state_d = ST_DONE;
          if (acc_q > RES_MAX) begin
            sum_d = RES_MAX[OPW-1:0];
            ovf_d = 1'b1;
          end else begin
            sum_d = acc_q[OPW-1:0];
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      mode_q     <= LOSS_L1;
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      s1_valid_q <= s1_valid_d;
      s1_val_q   <= s1_val_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_RUN);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = $signed(sum_q);
  assign bus.ovf       = ovf_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_loss_accum_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_loss_accum_stream                                             |
// | Self-checking bench for loss_accum_stream: directed jobs plus randomized   |
// | jobs checked against an element-by-element arithmetic loss model.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_loss_accum_stream;

  localparam int  TW      = 20;
  localparam int  TL      = 4;
  localparam int  TMAXN   = 1024;
  localparam longint RMAX = 524287;   // largest positive 20-bit value
  localparam int  ONE     = 4096;     // 1.0 in Q8.12

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [10:0] num;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  int q_yh[$];
  int q_y[$];

  loss_accum_stream_if #(.DW(TW), .LANES(TL)) tbif ();

  loss_accum_stream #(
    .IL(8), .FL(12), .LANES(TL), .MAXN(TMAXN), .GUARD(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .num     (num),
    .busy    (busy),
    .bus     (tbif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd_fx(input int lim);
    return int'($urandom_range(0, 2*lim - 1)) - lim;
  endfunction

  // Expected result straight from the loss definition over the job's elements.
  function automatic void model(input bit m, input int n, output longint res, output bit ov);
    longint tot, d, v;
    int ne;
    ne  = (n > TMAXN) ? TMAXN : n;
    tot = 0;
    ov  = 1'b0;
    for (int k = 0; k < ne; k++) begin
      d = longint'(q_yh[k]) - longint'(q_y[k]);
      if (!m) v = (d < 0) ? -d : d;
      else    v = (d * d) / ONE;
      if (v > RMAX) begin v = RMAX; ov = 1'b1; end
      tot += v;
    end
    if (tot > RMAX) begin res = RMAX; ov = 1'b1; end
    else res = tot;
  endfunction

  task automatic fill(input int n, input int lim);
    q_yh.delete();
    q_y.delete();
    for (int k = 0; k < n; k++) begin
      q_yh.push_back(rnd_fx(lim));
      q_y.push_back(rnd_fx(lim));
    end
  endtask

  task automatic drive_lanes(input int b, input int ne);
    int idx;
    for (int l = 0; l < TL; l++) begin
      idx = b*TL + l;
      if (idx < ne) begin
        tbif.yhat[l] = q_yh[idx][TW-1:0];
        tbif.y[l]    = q_y[idx][TW-1:0];
      end else begin
        tbif.yhat[l] = TW'($urandom);   // junk beyond the job must be masked
        tbif.y[l]    = TW'($urandom);
      end
    end
  endtask

  // Launch a job from IDLE, stream it, check latency/result, then acknowledge.
  task automatic run_job(input string tag, input bit m, input int n, input bit bub, input bit noise);
    int     ne, nb, lat;
    longint er;
    bit     eo;
    ne = (n > TMAXN) ? TMAXN : n;
    nb = (ne + TL - 1) / TL;
    model(m, n, er, eo);
    @(negedge clk);
    start = 1'b1; mode = m; num = 11'(n);
    @(negedge clk);
    start = 1'b0; mode = ~m; num = 11'd3;   // later changes must not matter
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    for (int b = 0; b < nb; b++) begin
      if (bub) begin
        tbif.in_valid = 1'b0;
        @(negedge clk);
      end
      drive_lanes(b, ne);
      tbif.in_valid = 1'b1;
      start = noise;
      if (b == 0) chk({tag, ".in_ready"}, 64'(tbif.in_ready), 64'd1);
      @(negedge clk);
    end
    // The negedge just reached is the first cycle after the final handshake.
    tbif.in_valid = noise;
    lat = 1;
    while (tbif.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd3);
    chk({tag, ".sum"}, {44'd0, tbif.sum}, 64'(er));
    chk({tag, ".ovf"}, 64'(tbif.ovf), 64'(eo));
    if (noise) begin
      repeat (2) @(negedge clk);
      chk({tag, ".held_valid"}, 64'(tbif.out_valid), 64'd1);
      chk({tag, ".held_sum"}, {44'd0, tbif.sum}, 64'(er));
    end
    tbif.out_ready = 1'b1;
    @(negedge clk);
    tbif.out_ready = 1'b0;
    tbif.in_valid  = 1'b0;
    start          = 1'b0;
    chk({tag, ".idle"}, {62'd0, tbif.out_valid, busy}, 64'd0);
  endtask

  initial begin
    longint er;
    bit     eo;

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; num = '0;
    tbif.in_valid = 1'b0; tbif.out_ready = 1'b0; tbif.yhat = '0; tbif.y = '0;
    repeat (3) @(negedge clk);
    chk("reset.out_valid", 64'(tbif.out_valid), 64'd0);
    chk("reset.in_ready", 64'(tbif.in_ready), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.sum", {44'd0, tbif.sum}, 64'd0);
    chk("reset.ovf", 64'(tbif.ovf), 64'd0);
    reset_n = 1'b1;

    // L1, two beats, second beat half masked: 8.5
    q_yh = '{ONE, -2*ONE, ONE/2, 3*ONE, ONE, ONE};
    q_y  = '{0, 0, 0, 0, 0, 0};
    model(1'b0, 6, er, eo);
    chk("t1.model", 64'(er), 64'h8800);
    run_job("t1", 1'b0, 6, 1'b0, 1'b0);

    // L2 with a bubble before every beat: 6.5
    q_yh = '{ONE + ONE/2, -2*ONE, 0, ONE/2};
    q_y  = '{0, 0, 0, 0};
    run_job("t2", 1'b1, 4, 1'b1, 1'b0);

    // Saturating job, then a clean job shows ovf cleared
    q_yh.delete(); q_y.delete();
    for (int k = 0; k < 16; k++) begin q_yh.push_back(100*ONE); q_y.push_back(0); end
    run_job("t3a", 1'b0, 16, 1'b0, 1'b0);
    q_yh = '{ONE}; q_y = '{0};
    run_job("t3b", 1'b0, 1, 1'b0, 1'b0);

    // Empty job: result next cycle, held while out_ready is low
    @(negedge clk);
    start = 1'b1; num = '0; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t4.out_valid", 64'(tbif.out_valid), 64'd1);
    chk("t4.sum", {44'd0, tbif.sum}, 64'd0);
    chk("t4.ovf", 64'(tbif.ovf), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4.hold", {42'd0, tbif.in_ready, tbif.out_valid, tbif.sum}, {43'd0, 1'b1, 20'd0});
    end
    tbif.out_ready = 1'b1;
    @(negedge clk);
    tbif.out_ready = 1'b0;
    chk("t4.idle", 64'(busy), 64'd0);

    // Reset after one of four beats, then a fresh job
    fill(16, 2*ONE);
    run_job("t5pre", 1'b0, 16, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; num = 11'd16;
    @(negedge clk);
    start = 1'b0;
    drive_lanes(0, 16);
    tbif.in_valid = 1'b1;
    @(negedge clk);
    tbif.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5.reset", {59'd0, tbif.in_ready, tbif.out_valid, busy, tbif.ovf, |tbif.sum}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fill(4, ONE);
    run_job("t5post", 1'b1, 4, 1'b0, 1'b0);

    // Beats offered in IDLE are refused; start pulses mid-job are ignored
    @(negedge clk);
    tbif.in_valid = 1'b1;
    drive_lanes(0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t6.idle_ready", {62'd0, tbif.in_ready, busy}, 64'd0);
    end
    tbif.in_valid = 1'b0;
    fill(10, 8*ONE);
    run_job("t6", 1'b0, 10, 1'b0, 1'b1);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      bit m;
      int n;
      m = 1'($urandom);
      n = int'($urandom_range(1, 40));
      fill(n, m ? 4*ONE : ((j % 2) != 0 ? 524288 : 16*ONE));
      run_job($sformatf("rnd%0d", j), m, n, 1'($urandom), 1'b0);
    end

    // Oversized count is limited to MAXN
    fill(1100, 256);
    run_job("maxn", 1'b0, 1100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
